// File: rtl/alu_sequencer_if.sv
// Bundle of the sequencer's instruction, host-write, external-ALU and retire signals.
// The sequencer takes the slave view; the host/ALU environment takes the master view.
`timescale 1ns/1ps
interface alu_sequencer_if #(parameter int unsigned N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [11:0]  instr;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic [N-1:0] alu_y;
  logic         alu_cout;
  logic         alu_z;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         res_cout;
  logic         res_zero;
  logic         res_err;
  logic         busy;

  modport slave (
    input  in_valid, instr, wr_en, wr_addr, wr_data, alu_y, alu_cout, alu_z,
    output in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_cout,
           res_zero, res_err, busy
  );

  modport master (
    output in_valid, instr, wr_en, wr_addr, wr_data, alu_y, alu_cout, alu_z,
    input  in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_cout,
           res_zero, res_err, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-phase sequencer around an external combinational ALU: fetch operands from an
// 8-entry register file (r0 hardwired to zero), execute, then retire and write back.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int unsigned N = 32
) (
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DECODE    = 2'd1;
  localparam logic [1:0] S_EXECUTE   = 2'd2;
  localparam logic [1:0] S_WRITEBACK = 2'd3;
  localparam logic [2:0] SEL_ILLEGAL = 3'b110;

  logic [1:0]   r_state;
  logic [11:0]  r_instr;
  logic [N-1:0] r_regs [8];
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [2:0]   r_alu_sel;
  logic [N-1:0] r_y;
  logic         r_cout;
  logic         r_z;
  logic         r_res_valid;
  logic [N-1:0] r_res_data;
  logic         r_res_cout;
  logic         r_res_zero;
  logic         r_res_err;

  logic [2:0] w_sel;
  logic [2:0] w_rd;
  logic [2:0] w_rs1;
  logic [2:0] w_rs2;
  logic       w_illegal;

  assign w_sel     = r_instr[2:0];
  assign w_rd      = r_instr[5:3];
  assign w_rs1     = r_instr[8:6];
  assign w_rs2     = r_instr[11:9];
  assign w_illegal = (w_sel == SEL_ILLEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_y         <= '0;
      r_cout      <= 1'b0;
      r_z         <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_cout  <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Host write lands on the same edge as accept, so DECODE sees the new value.
          if (bus.wr_en && (bus.wr_addr != 3'd0)) r_regs[bus.wr_addr] <= bus.wr_data;
          if (bus.in_valid) begin
            r_instr <= bus.instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_alu_a   <= r_regs[w_rs1];
          r_alu_b   <= r_regs[w_rs2];
          r_alu_sel <= w_sel;
          r_state   <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_y     <= bus.alu_y;
          r_cout  <= bus.alu_cout;
          r_z     <= bus.alu_z;
          r_state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          r_res_valid <= 1'b1;
          if (w_illegal) begin
            r_res_data <= '0;
            r_res_cout <= 1'b0;
            r_res_zero <= 1'b1;
            r_res_err  <= 1'b1;
          end else begin
            r_res_data <= r_y;
            r_res_cout <= r_cout;
            r_res_zero <= r_z;
            r_res_err  <= 1'b0;
            if (w_rd != 3'd0) r_regs[w_rd] <= r_y;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_cout  = r_res_cout;
  assign bus.res_zero  = r_res_zero;
  assign bus.res_err   = r_res_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions push hand-computed results,
// a negedge monitor pops and compares them whenever res_valid is seen.
`timescale 1ns/1ps
module tb_alu_sequencer;
  localparam int unsigned N = 32;

  typedef struct {
    logic [N-1:0] data;
    logic         cout;
    logic         zero;
    logic         err;
    int unsigned  acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;
  exp_t        sb[$];

  logic [N-1:0] m_y;
  logic [N:0]   m_t;
  logic         m_c;

  alu_sequencer_if #(.N(N)) bus ();

  alu_sequencer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference external ALU; opcode 110 returns junk the sequencer must suppress.
  always_comb begin
    m_t = '0;
    m_y = '0;
    m_c = 1'b0;
    case (bus.alu_sel)
      3'b000: m_y = bus.alu_a & bus.alu_b;
      3'b001: m_y = bus.alu_a | bus.alu_b;
      3'b010: begin
        m_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_y = m_t[N-1:0];
        m_c = m_t[N];
      end
      3'b011: begin
        m_y = bus.alu_a - bus.alu_b;
        m_c = (bus.alu_a >= bus.alu_b);
      end
      3'b100: m_y = bus.alu_a ^ bus.alu_b;
      3'b101: begin
        m_y = bus.alu_a << 1;
        m_c = bus.alu_a[N-1];
      end
      3'b110: begin
        m_y = 32'hDEAD_BEEF;
        m_c = 1'b1;
      end
      default: m_y = bus.alu_a;
    endcase
  end
  assign bus.alu_y    = m_y;
  assign bus.alu_cout = m_c;
  assign bus.alu_z    = (m_y == '0);

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [N-1:0] d, input logic c, input logic z, input logic e);
    exp_t r;
    r.data = d;
    r.cout = c;
    r.zero = z;
    r.err  = e;
    r.acc  = 0;
    return r;
  endfunction

  function automatic logic [11:0] ins(input logic [2:0] sel, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {rs2, rs1, rd, sel};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", {31'b0, bus.res_valid}, '0);
      end else begin
        e = sb.pop_front();
        chk("res_data", bus.res_data, e.data);
        chk("res_cout", {31'b0, bus.res_cout}, {31'b0, e.cout});
        chk("res_zero", {31'b0, bus.res_zero}, {31'b0, e.zero});
        chk("res_err",  {31'b0, bus.res_err},  {31'b0, e.err});
        chk("latency",  cyc - e.acc, 32'd4);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge (DECODE).
  task automatic issue(input logic [11:0] i, input exp_t e_in, input bit keep_valid,
                       input int exp_wait);
    exp_t        e;
    int unsigned n;
    e = e_in;
    n = 0;
    bus.in_valid = 1'b1;
    bus.instr    = i;
    while (!bus.in_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      if (exp_wait >= 0) chk("in_ready_wait", n, exp_wait);
      e.acc = cyc;
      sb.push_back(e);
      @(negedge clk);
      if (!keep_valid) bus.in_valid = 1'b0;
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [N-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [2:0] r, input logic [N-1:0] v);
    issue(ins(3'b111, 3'd0, r, 3'd0), mk(v, 1'b0, (v == '0), 1'b0), 1'b0, -1);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr    = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    repeat (2) @(negedge clk);

    chk("rst_res_valid", {31'b0, bus.res_valid}, '0);
    chk("rst_busy",      {31'b0, bus.busy}, '0);
    chk("rst_alu_a",     bus.alu_a, '0);
    chk("rst_alu_b",     bus.alu_b, '0);
    chk("rst_alu_sel",   {29'b0, bus.alu_sel}, '0);
    chk("rst_res_data",  bus.res_data, '0);
    chk("rst_res_flags", {28'b0, bus.res_cout, bus.res_zero, bus.res_err, 1'b0}, '0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // Basic add
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    issue(ins(3'b010, 3'd3, 3'd1, 3'd2), mk(32'd8, 1'b0, 1'b0, 1'b0), 1'b0, 0);
    drain();
    read_reg(3'd3, 32'd8);

    // Add with carry out and zero result
    host_write(3'd1, 32'hFFFF_FFFF);
    host_write(3'd2, 32'd1);
    host_write(3'd6, 32'h77);
    issue(ins(3'b010, 3'd6, 3'd1, 3'd2), mk(32'd0, 1'b1, 1'b1, 1'b0), 1'b0, -1);
    drain();
    read_reg(3'd6, 32'd0);

    // Subtract to zero, opcode visible during EXECUTE
    host_write(3'd1, 32'hFF);
    host_write(3'd2, 32'hFF);
    host_write(3'd4, 32'h1234);
    issue(ins(3'b011, 3'd4, 3'd1, 3'd2), mk(32'd0, 1'b1, 1'b1, 1'b0), 1'b0, -1);
    @(negedge clk);
    chk("exec_alu_sel", {29'b0, bus.alu_sel}, 32'd3);
    chk("exec_alu_a", bus.alu_a, 32'hFF);
    drain();
    read_reg(3'd4, 32'd0);

    // Illegal opcode
    host_write(3'd5, 32'h55);
    issue(ins(3'b110, 3'd5, 3'd1, 3'd2), mk(32'd0, 1'b0, 1'b1, 1'b1), 1'b0, -1);
    drain();
    read_reg(3'd5, 32'h55);

    // Host write with accept in the same cycle; write during DECODE is ignored
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_data = 32'hA;
    issue(ins(3'b000, 3'd2, 3'd1, 3'd1), mk(32'hA, 1'b0, 1'b0, 1'b0), 1'b0, 0);
    bus.wr_data = 32'h7;
    @(negedge clk);
    chk("same_cycle_alu_a", bus.alu_a, 32'hA);
    chk("same_cycle_alu_b", bus.alu_b, 32'hA);
    bus.wr_en = 1'b0;
    drain();
    chk("hold_alu_a", bus.alu_a, 32'hA);
    read_reg(3'd1, 32'hA);
    read_reg(3'd2, 32'hA);

    // rd == rs1 reads old value, writes result
    issue(ins(3'b010, 3'd1, 3'd1, 3'd2), mk(32'h14, 1'b0, 1'b0, 1'b0), 1'b0, -1);
    drain();
    read_reg(3'd1, 32'h14);
    read_reg(3'd0, 32'd0);

    // Reset during EXECUTE aborts the instruction
    host_write(3'd6, 32'h99);
    issue(ins(3'b010, 3'd7, 3'd6, 3'd6), mk(32'h132, 1'b0, 1'b0, 1'b0), 1'b0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_busy",     {31'b0, bus.busy}, '0);
    chk("abort_alu_a",    bus.alu_a, '0);
    chk("abort_res_data", bus.res_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    issue(ins(3'b111, 3'd0, 3'd1, 3'd0), mk(32'd0, 1'b0, 1'b1, 1'b0), 1'b0, 0);
    drain();
    for (int r = 2; r < 8; r++) read_reg(r[2:0], 32'd0);

    // Back-to-back stream with in_valid held high
    host_write(3'd1, 32'd3);
    host_write(3'd2, 32'd4);
    issue(ins(3'b010, 3'd0, 3'd1, 3'd2), mk(32'd7, 1'b0, 1'b0, 1'b0), 1'b1, 0);
    issue(ins(3'b001, 3'd3, 3'd0, 3'd1), mk(32'd3, 1'b0, 1'b0, 1'b0), 1'b1, 3);
    issue(ins(3'b100, 3'd4, 3'd1, 3'd2), mk(32'd7, 1'b0, 1'b0, 1'b0), 1'b1, 3);
    issue(ins(3'b010, 3'd0, 3'd0, 3'd0), mk(32'd0, 1'b0, 1'b1, 1'b0), 1'b0, 3);
    drain();
    read_reg(3'd0, 32'd0);
    read_reg(3'd3, 32'd3);
    read_reg(3'd4, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
